// File: rtl/quant_pkg.sv
// Shared fixed-point quantization helpers and the de-emphasis filter's
// default coefficients and controller state encoding.
package quant_pkg;

  localparam int BITS = 10;

  // Working width of the dequantization helper; wide enough for any
  // full-precision product of two samples up to 64 bits each.
  localparam int QW = 128;

  localparam int DEF_B0 = 178;
  localparam int DEF_B1 = 178;
  localparam int DEF_A1 = -666;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_ACC,
    S_WRITE
  } deemph_state_e;

  function automatic logic signed [QW-1:0] QUANTIZE(
    input logic signed [QW-1:0] value,
    input int                   bits
  );
    return value <<< bits;
  endfunction

  // Divide by 2^bits rounding toward zero, so small negative values
  // collapse to 0 instead of leaking a -1 into the feedback path.
  function automatic logic signed [QW-1:0] DEQUANTIZE(
    input logic signed [QW-1:0] product,
    input int                   bits
  );
    logic signed [QW-1:0] bias;
    bias = (QW'(1) <<< bits) - QW'(1);
    if (product < 0)
      return (product + bias) >>> bits;
    else
      return product >>> bits;
  endfunction

endpackage

// File: rtl/iir_deemph.sv
// First-order IIR de-emphasis filter between two FIFOs:
// y[n] = DEQ(B0*x[n]) + DEQ(B1*x[n-1]) - DEQ(A1*y[n-1]), one sample per 4 cycles.
module iir_deemph
  import quant_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = quant_pkg::BITS,
  parameter int B0         = DEF_B0,
  parameter int B1         = DEF_B1,
  parameter int A1         = DEF_A1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din
);

  localparam int PW = 2 * DATA_WIDTH;

  localparam logic signed [PW-1:0] C_B0 = PW'(B0);
  localparam logic signed [PW-1:0] C_B1 = PW'(B1);
  localparam logic signed [PW-1:0] C_A1 = PW'(A1);

  deemph_state_e r_state;

  logic signed [DATA_WIDTH-1:0] r_xReg;
  logic signed [DATA_WIDTH-1:0] r_xPrev;
  logic signed [DATA_WIDTH-1:0] r_yPrev;
  logic signed [DATA_WIDTH-1:0] r_yReg;
  logic signed [PW-1:0]         r_prodB0;
  logic signed [PW-1:0]         r_prodB1;
  logic signed [PW-1:0]         r_prodA1;

  logic signed [PW-1:0]         w_xExt;
  logic signed [PW-1:0]         w_xPrevExt;
  logic signed [PW-1:0]         w_yPrevExt;
  logic signed [DATA_WIDTH-1:0] w_sum;

  assign w_xExt     = PW'(r_xReg);
  assign w_xPrevExt = PW'(r_xPrev);
  assign w_yPrevExt = PW'(r_yPrev);

  // Each term is dequantized on its own before summing; the sum then wraps.
  assign w_sum = DATA_WIDTH'(DEQUANTIZE(QW'(r_prodB0), BITS))
               + DATA_WIDTH'(DEQUANTIZE(QW'(r_prodB1), BITS))
               - DATA_WIDTH'(DEQUANTIZE(QW'(r_prodA1), BITS));

  // Handshakes are gated by reset so neither FIFO is touched while it is held.
  assign in_rd_en  = !reset && (r_state == S_IDLE)  && !in_empty;
  assign out_wr_en = !reset && (r_state == S_WRITE) && !out_full;
  assign out_din   = r_yReg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_xReg   <= '0;
      r_xPrev  <= '0;
      r_yPrev  <= '0;
      r_yReg   <= '0;
      r_prodB0 <= '0;
      r_prodB1 <= '0;
      r_prodA1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!in_empty) begin
            r_xReg  <= $signed(in_dout);
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          r_prodB0 <= w_xExt * C_B0;
          r_prodB1 <= w_xPrevExt * C_B1;
          r_prodA1 <= w_yPrevExt * C_A1;
          r_state  <= S_ACC;
        end
        S_ACC: begin
          r_yReg  <= w_sum;
          r_xPrev <= r_xReg;
          r_yPrev <= w_sum;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (!out_full)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_deemph.sv
// Self-checking bench for iir_deemph: directed impulse, rounding, latency,
// backpressure and reset scenarios, then a randomized stream against a model.
module tb_iir_deemph;

  localparam int DW      = 32;
  localparam int TB_BITS = 10;
  localparam int N_RAND  = 1000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_rd_en;
  logic          in_empty = 1'b1;
  logic [DW-1:0] in_dout = '0;
  logic          out_wr_en;
  logic          out_full = 1'b0;
  logic [DW-1:0] out_din;

  int checks = 0;
  int errors = 0;

  iir_deemph dut (
    .clock    (clock),
    .reset    (reset),
    .in_rd_en (in_rd_en),
    .in_empty (in_empty),
    .in_dout  (in_dout),
    .out_wr_en(out_wr_en),
    .out_full (out_full),
    .out_din  (out_din)
  );

  always #5 clock = ~clock;

  // Reference: plain integer arithmetic, where division truncates toward zero.
  function automatic longint deq(input longint p);
    return p / (longint'(1) << TB_BITS);
  endfunction

  function automatic int refY(input int x, input int xPrev, input int yPrev);
    longint s;
    s = deq(longint'(178) * longint'(x))
      + deq(longint'(178) * longint'(xPrev))
      - deq(longint'(-666) * longint'(yPrev));
    return int'(s);
  endfunction

  task automatic checkOutput(input string tag, input logic signed [DW-1:0] observed,
                             input logic signed [DW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b0;
    in_dout  = 32'd77;
    out_full = 1'b0;
    #1;
    checkFlag("rstRdEn", in_rd_en, 1'b0);
    checkFlag("rstWrEn", out_wr_en, 1'b0);
    checkOutput("rstDin", out_din, '0);
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;
  endtask

  // Push one sample and wait for its write; lat counts cycles from pop to write.
  task automatic applyStimulus(input logic [DW-1:0] x, input bit holdInput,
                               output logic [DW-1:0] y, output int lat);
    int n;
    @(negedge clock);
    in_empty = 1'b0;
    in_dout  = x;
    #1;
    n = 0;
    while (in_rd_en !== 1'b1 && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    checkFlag("popSeen", in_rd_en, 1'b1);
    lat = 0;
    y   = 'x;
    if (in_rd_en === 1'b1) begin
      while (lat < 20) begin
        @(negedge clock);
        if (!holdInput) in_empty = 1'b1;
        #1;
        lat++;
        checkFlag("rdLowAfterPop", in_rd_en, 1'b0);
        if (out_wr_en === 1'b1) break;
      end
      y = out_din;
    end
    checkFlag("writeSeen", out_wr_en, 1'b1);
    in_empty = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] y;
    logic [DW-1:0] expV;
    int            lat;
    logic [DW-1:0] inQ[$];
    logic [DW-1:0] expQ[$];
    int            xPrev;
    int            yPrev;
    int            writes;
    int            cyc;

    doReset();

    // Impulse response with the default coefficients
    applyStimulus(32'd1024, 1'b1, y, lat);
    checkOutput("impulse0", y, 32'sd178);
    checkOutput("latency", lat, 3);
    applyStimulus(32'd0, 1'b0, y, lat);
    checkOutput("impulse1", y, 32'sd293);
    applyStimulus(32'd0, 1'b0, y, lat);
    checkOutput("impulse2", y, 32'sd190);

    // Rounding toward zero on a tiny negative input
    doReset();
    applyStimulus(-32'sd1, 1'b0, y, lat);
    checkOutput("roundNeg", y, 32'sd0);
    applyStimulus(32'd0, 1'b0, y, lat);
    checkOutput("roundNext", y, 32'sd0);

    // Backpressure: output held full for five cycles in the write state
    doReset();
    @(negedge clock);
    out_full = 1'b1;
    in_empty = 1'b0;
    in_dout  = 32'd1024;
    #1;
    checkFlag("bpPop", in_rd_en, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      in_dout = 32'd555;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      #1;
      checkFlag("bpWrLow", out_wr_en, 1'b0);
      checkFlag("bpRdLow", in_rd_en, 1'b0);
      checkOutput("bpDinStable", out_din, 32'sd178);
    end
    @(negedge clock);
    out_full = 1'b0;
    #1;
    checkFlag("bpWrRelease", out_wr_en, 1'b1);
    checkOutput("bpDinRelease", out_din, 32'sd178);
    in_empty = 1'b1;
    applyStimulus(32'd0, 1'b0, y, lat);
    checkOutput("bpHistoryKept", y, 32'sd293);

    // Reset in the accumulate state discards the sample and its history
    doReset();
    @(negedge clock);
    in_empty = 1'b0;
    in_dout  = 32'd1024;
    #1;
    checkFlag("midPop", in_rd_en, 1'b1);
    @(negedge clock);
    in_empty = 1'b1;
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkFlag("midRstWr", out_wr_en, 1'b0);
    checkOutput("midRstDin", out_din, '0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(32'd1024, 1'b0, y, lat);
    checkOutput("postRstOut", y, 32'sd178);
    checkOutput("postRstLat", lat, 3);

    // Randomized stream with random empty/full handshakes
    doReset();
    for (int i = 0; i < N_RAND; i++) begin
      if ($urandom_range(0, 1) == 0)
        inQ.push_back(DW'($signed($urandom_range(0, 8191)) - 4096));
      else
        inQ.push_back(DW'($urandom));
    end
    xPrev  = 0;
    yPrev  = 0;
    writes = 0;
    cyc    = 0;
    while (writes < N_RAND && cyc < 40000) begin
      @(negedge clock);
      cyc++;
      in_empty = (inQ.size() == 0) || ($urandom_range(0, 3) == 0);
      in_dout  = in_empty ? '0 : inQ[0];
      out_full = ($urandom_range(0, 3) == 0);
      #1;
      if (in_rd_en === 1'b1) begin
        checkFlag("popWhileEmpty", in_empty, 1'b0);
        if (inQ.size() > 0) begin
          int x;
          int yv;
          x  = int'($signed(inQ.pop_front()));
          yv = refY(x, xPrev, yPrev);
          xPrev = x;
          yPrev = yv;
          expQ.push_back(DW'(yv));
        end
      end
      if (out_wr_en === 1'b1) begin
        checkFlag("wrWhileFull", out_full, 1'b0);
        expV = (expQ.size() > 0) ? expQ.pop_front() : 'x;
        checkOutput("streamSample", out_din, expV);
        writes++;
      end
    end
    out_full = 1'b0;
    in_empty = 1'b1;
    checkOutput("streamWrites", writes, N_RAND);
    checkOutput("streamLeftover", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
